// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// The grant is evaluated combinationally and captured in a one-entry response buffer.

module alu_share_alu #(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);
   logic [4:0] shamt;

   always_comb begin
      shamt     = b_i[4:0];
      result_o  = '0;
      illegal_o = 1'b0;
      case (op_i)
         4'd0:    result_o = a_i + b_i;
         4'd1:    result_o = a_i - b_i;
         4'd2:    result_o = a_i << shamt;
         4'd3:    result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         4'd4:    result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
         4'd5:    result_o = a_i ^ b_i;
         4'd6:    result_o = a_i >> shamt;
         4'd7:    result_o = $signed(a_i) >>> shamt;
         4'd8:    result_o = a_i | b_i;
         4'd9:    result_o = a_i & b_i;
         default: illegal_o = 1'b1;
      endcase
   end
endmodule

module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal
);
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_src_q, rsp_src_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_illegal_q, rsp_illegal_d;
   logic             prio_q, prio_d;

   logic             can_accept;
   logic             winner;
   logic             grant;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic             alu_illegal;

   alu_share_alu #(.WIDTH(WIDTH)) u_alu (
      .op_i      (alu_op),
      .a_i       (alu_a),
      .b_i       (alu_b),
      .result_o  (alu_result),
      .illegal_o (alu_illegal)
   );

   always_comb begin
      can_accept = !rsp_valid_q || rsp_ready;
      winner     = (req0_valid && req1_valid) ? prio_q : !req0_valid;
      // Readies are held low during reset so nothing is accepted into a buffer being cleared.
      req0_ready = !reset && can_accept && req0_valid && (winner == 1'b0);
      req1_ready = !reset && can_accept && req1_valid && (winner == 1'b1);
      grant      = req0_ready || req1_ready;
      alu_op     = winner ? req1_op : req0_op;
      alu_a      = winner ? req1_a  : req0_a;
      alu_b      = winner ? req1_b  : req0_b;
   end

   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_src_d     = rsp_src_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_illegal_d = rsp_illegal_q;
      prio_d        = prio_q;
      if (grant) begin
         rsp_valid_d   = 1'b1;
         rsp_result_d  = alu_result;
         rsp_src_d     = winner;
         rsp_tag_d     = winner ? req1_tag : req0_tag;
         rsp_illegal_d = alu_illegal;
         prio_d        = !winner;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_src_q     <= 1'b0;
         rsp_tag_q     <= '0;
         rsp_illegal_q <= 1'b0;
         prio_q        <= 1'b0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_src_q     <= rsp_src_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_illegal_q <= rsp_illegal_d;
         prio_q        <= prio_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_src     = rsp_src_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench for alu_share_arbiter with a response scoreboard and a random soak phase.

module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_op = '0, req1_op = '0, req0_tag = '0, req1_tag = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_src, rsp_illegal;
   logic [3:0]  rsp_tag;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
   );

   typedef struct {
      logic        rst;
      logic        v0; logic [3:0] op0; logic [31:0] a0; logic [31:0] b0; logic [3:0] t0;
      logic        v1; logic [3:0] op1; logic [31:0] a1; logic [31:0] b1; logic [3:0] t1;
      logic        rr;
      logic        er0, er1;
      logic [31:0] eres;
      logic        eill;
   } vec_t;

   typedef struct {
      logic [31:0] result;
      logic        src;
      logic [3:0]  tag;
      logic        ill;
   } rsp_t;

   vec_t vecs[$];
   rsp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic m_prio = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mkv(input logic rst,
                                input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                                input logic [31:0] b0, input logic [3:0] t0,
                                input logic v1, input logic [3:0] op1, input logic [31:0] a1,
                                input logic [31:0] b1, input logic [3:0] t1,
                                input logic rr, input logic er0, input logic er1,
                                input logic [31:0] eres, input logic eill);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
      v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
      v.rr = rr; v.er0 = er0; v.er1 = er1; v.eres = eres; v.eill = eill;
      return v;
   endfunction

   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      int          sh;
      sh = int'(b % 32);
      case (op)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a << sh;
         4'd3: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd4: r = (a < b) ? 32'd1 : 32'd0;
         4'd5: r = a ^ b;
         4'd6: r = a >> sh;
         4'd7: r = a[31] ? ~((~a) >> sh) : (a >> sh);
         4'd8: r = a | b;
         4'd9: r = a & b;
         default: r = 32'd0;
      endcase
      return {(op > 4'd9), r};
   endfunction

   task automatic step(input vec_t v);
      rsp_t e;
      @(posedge clk); #1;
      reset = v.rst;
      req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0;
      req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1;
      rsp_ready = v.rr;
      @(negedge clk);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
      if (rsp_valid && exp_q.size() != 0) begin
         chk("rsp_result", rsp_result, exp_q[0].result);
         chk("rsp_src", {31'd0, rsp_src}, {31'd0, exp_q[0].src});
         chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, exp_q[0].tag});
         chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, exp_q[0].ill});
      end
      if (v.rst) begin
         exp_q.delete();
         m_prio = 1'b0;
      end else if (rsp_valid && v.rr && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
      end
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, v.er0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, v.er1});
      if (!v.rst && ((v.v0 && v.er0) || (v.v1 && v.er1))) begin
         e.result = v.eres; e.src = v.er1; e.tag = v.er1 ? v.t1 : v.t0; e.ill = v.eill;
         exp_q.push_back(e);
         m_prio = !v.er1;
      end
   endtask

   initial begin
      vec_t rv;
      logic can, w;
      logic [32:0] ra;
      logic g0 = 1'b1, g1 = 1'b1;

      //              rst v0 op0   a0            b0            t0    v1 op1   a1            b1            t1    rr er0 er1 eres          ill
      vecs.push_back(mkv(1, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(1, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 1, 4'd0, 32'd5,        32'd7,        4'd3, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 1, 0, 32'd12,       0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(1, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 0, 0, 32'd0,        0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mkv(0, 1, 4'd1, 32'd10, 32'd3, 4'd1, 1, 4'd7, 32'h8000_0000, 32'd4, 4'd2, 1,
                            (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 32'd7 : 32'hF800_0000, 0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 4'd3, 32'hFFFF_FFFF, 32'd1,        4'd4, 1, 0, 1, 32'd1,        0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mkv(0, 1, 4'd5, 32'h0F0F, 32'h00FF, 4'd5, 0, 4'd0, 32'd0, 32'd0, 4'd0, 0, 0, 0, 32'd0, 0));
      vecs.push_back(mkv(0, 1, 4'd5, 32'h0F0F,     32'h00FF,     4'd5, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 1, 0, 32'h0FF0,     0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 1, 4'd12, 32'd1,       32'd1,        4'd6, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 1, 0, 32'd0,        1));
      vecs.push_back(mkv(0, 1, 4'd8, 32'hF0,       32'h0F,       4'd7, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 1, 0, 32'hFF,       0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 4'd2, 32'd1,        32'd33,       4'd8, 1, 0, 1, 32'd2,        0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 4'd4, 32'd1,        32'hFFFF_FFFF, 4'd9, 1, 0, 1, 32'd1,       0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 1, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA, 1, 4'd6, 32'h8000_0000, 32'd4,      4'hB, 1, 1, 0, 32'h0F00_0F00, 0));
      vecs.push_back(mkv(0, 1, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA, 1, 4'd6, 32'h8000_0000, 32'd4,      4'hB, 0, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(1, 1, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA, 1, 4'd6, 32'h8000_0000, 32'd4,      4'hB, 0, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 1, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA, 1, 4'd6, 32'h8000_0000, 32'd4,      4'hB, 1, 1, 0, 32'h0F00_0F00, 0));
      vecs.push_back(mkv(0, 0, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA, 1, 4'd6, 32'h8000_0000, 32'd4,      4'hB, 1, 0, 1, 32'h0800_0000, 0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));
      vecs.push_back(mkv(0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 0, 4'd0, 32'd0,        32'd0,        4'd0, 1, 0, 0, 32'd0,        0));

      step(vecs[0]);
      step(vecs[1]);
      chk("reset_result", rsp_result, 32'd0);
      chk("reset_src", {31'd0, rsp_src}, 32'd0);
      chk("reset_tag", {28'd0, rsp_tag}, 32'd0);
      chk("reset_illegal", {31'd0, rsp_illegal}, 32'd0);
      for (int i = 2; i < vecs.size(); i++) step(vecs[i]);

      // Random soak: un-granted requesters hold their operation stable.
      rv = vecs[vecs.size()-1];
      for (int n = 0; n < 300; n++) begin
         rv.rst = 1'b0;
         if (g0) begin
            rv.v0 = $urandom_range(0, 1); rv.op0 = 4'($urandom_range(0, 15));
            rv.a0 = $urandom; rv.b0 = $urandom; rv.t0 = 4'($urandom_range(0, 15));
         end
         if (g1) begin
            rv.v1 = $urandom_range(0, 1); rv.op1 = 4'($urandom_range(0, 15));
            rv.a1 = $urandom; rv.b1 = $urandom; rv.t1 = 4'($urandom_range(0, 15));
         end
         rv.rr  = ($urandom_range(0, 3) != 0);
         can    = (exp_q.size() == 0) || rv.rr;
         w      = (rv.v0 && rv.v1) ? m_prio : !rv.v0;
         rv.er0 = can && rv.v0 && !w;
         rv.er1 = can && rv.v1 && w;
         ra     = w ? ref_alu(rv.op1, rv.a1, rv.b1) : ref_alu(rv.op0, rv.a0, rv.b0);
         rv.eres = ra[31:0];
         rv.eill = ra[32];
         step(rv);
         g0 = !rv.v0 || rv.er0;
         g1 = !rv.v1 || rv.er1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters, for example the main execute path and an auxiliary address/compare path.
- Each requester presents an operand pair and a 4-bit opselect over a valid/ready handshake.
- Round-robin arbitration picks at most one request per cycle. The selected request is evaluated combinationally and captured in a single-entry registered response buffer, returned with source ID and tag.
- Sits in the execute stage; instantiates the team ALU internally.

Parameters:
- WIDTH, 32, operand/result width; passed to the internal ALU.
- TAG_W, 4, width of the opaque requester tag carried through to the response.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  4  requester 0 opselect.
- req0_tag  input  TAG_W  requester 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_tag  same as requester 0, for requester 1.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  ALU result.
- rsp_src  output  1  index of the requester that issued it.
- rsp_tag  output  TAG_W  tag of the issuing request.
- rsp_illegal  output  1  opselect was outside 0..9.

Behaviour:
- ALU encoding (fixed):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Shift amount is operand B bits [4:0].
  - Opselect 10..15 yields result 0 with rsp_illegal=1. It still completes normally and is not dropped.
- State:
  - rsp buffer: valid, result, src, tag, illegal.
  - Round-robin priority pointer prio (1 bit): 0 favours requester 0.
- Buffer can accept: can_accept = !rsp_valid | rsp_ready. Same-cycle drain and refill is allowed, so throughput is 1 op/cycle.
- Arbitration (combinational):
  - Only valid requesters are eligible.
  - One eligible: that one wins.
  - Both eligible: requester prio wins.
  - reqN_ready = can_accept & (winner == N).
  - ready is never asserted to a non-winner or when the buffer cannot accept.
  - ready may depend on valid. Requesters must hold inputs stable while valid & !ready.
- On a grant (any reqN_valid & reqN_ready):
  - Buffer loads the ALU result of the winner's operands, src=N, tag, illegal.
  - rsp_valid=1 next cycle.
  - prio <= ~N, so the other requester is favoured next.
- prio is unchanged when nothing is granted.
- No grant but rsp_valid & rsp_ready: rsp_valid <= 0; data fields hold their last value.
- Back-pressure: while rsp_valid & !rsp_ready, both readies are 0 and the buffer holds all fields stable.
- Latency: 1 cycle from grant to rsp_valid.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants strictly alternate. Worst-case wait for either requester is 1 grant.
- Reset (synchronous, takes priority over everything):
  - rsp_valid=0, rsp_result=0, rsp_src=0, rsp_tag=0, rsp_illegal=0, prio=0.
  - Reset asserted mid-operation discards the buffered response with no output handshake.
  - During reset, req0_ready = req1_ready = 0.
- The ALU path is combinational within the grant cycle; no multicycle ops.

Test Plan:
1. Single requester: req0 ADD a=5, b=7, tag=3, rsp_ready=1. Required: req0_ready=1 that cycle; next cycle rsp_valid=1, result=12, src=0, tag=3, illegal=0.
2. Contention after reset:
   - Both valid every cycle: req0 SUB a=10, b=3; req1 SRA a=0x80000000, b=4; rsp_ready=1.
   - Required grant order 0,1,0,1: responses alternate 7 (src 0) and 0xF8000000 (src 1).
3. Back-pressure:
   - Grant req1 SLT a=0xFFFFFFFF, b=1 → response result=1.
   - Hold rsp_ready=0 for 3 cycles with req0 valid. Required: req0_ready=0 throughout; response fields stable.
   - Raise rsp_ready. Required: req0 granted in that same cycle.
4. Illegal op: req0 op=4'b1100, a=1, b=1. Required: response result=0, illegal=1, src=0. A following legal op from req0 (OR a=0xF0, b=0x0F) returns 0xFF with illegal=0.
5. Shift masking:
   - req1 SLL a=1, b=33 → result 2 (shift by 1).
   - req1 SLTU a=1, b=0xFFFFFFFF → result 1.
6. Reset mid-operation: assert reset while rsp_valid=1 and both requesters valid. Required: next cycle rsp_valid=0 and both readies 0. After reset, with both valid, the first grant goes to requester 0.
